histogram_frame_controller: RTL and testbench

- Owns and sequences the 256-bin, 20-bit histogram dual-port RAM used by the CameraLCD path.
- Per frame it runs four phases: clear all bins, accumulate one grey pixel per cycle (read-modify-write with forwarding), drain, then scan the bins to produce the max bin value and the 50%-cumulative threshold bin.
- Between frames it grants the RAM read port to the histogram displayer, so the displayer reads a stable, completed histogram.

---
 rtl/histogram_frame_controller_pkg.sv | 28 ++
 rtl/histogram_accum_pipe.sv | 73 +++++++
 rtl/histogram_frame_controller.sv | 215 +++++++++++++++++++++
 tb/tb_histogram_frame_controller.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_frame_controller_pkg.sv
// histogram_frame_controller_pkg
// Shared definitions for the histogram frame controller and its
// read-modify-write pipeline: sizing constants, the controller state
// encoding and the saturating increment used for bins and the pixel total.
package histogram_frame_controller_pkg;

   localparam int HIST_BINS   = 256;
   localparam int HIST_ADDR_W = 8;
   localparam int HIST_CNT_W  = 20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ACCUM,
      ST_DRAIN,
      ST_SCAN,
      ST_DONE
   } hist_state_t;

   // Counts stick at all-ones instead of wrapping to zero.
   function automatic logic [HIST_CNT_W-1:0] sat_inc(input logic [HIST_CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + HIST_CNT_W'(1);
   endfunction

endpackage

// File: rtl/histogram_accum_pipe.sv
// histogram_accum_pipe
// Two-stage read-modify-write pipeline that adds one to a histogram bin per
// accepted pixel.
//   S1: the pixel is the RAM read address; address and valid are registered.
//   S2: the bin is rewritten with sat_inc(base).
// The RAM read in S1 cannot observe a write landing in that same cycle, so
// the last write actually presented to the RAM write port is tracked and
// forwarded when it hits the S2 address. The tracked write comes from the
// controller's muxed write port, which also covers the final clear write
// colliding with the first accumulated pixel.
// Ports:
//   clk_sys, rst        clock, synchronous active-high reset
//   accept              pixel accepted this cycle
//   pixel               bin index of the accepted pixel
//   rd_data             RAM port A data (1-cycle latency)
//   port_wr_en/addr/data  write actually driven to the RAM this cycle
//   rd_addr             S1 read address
//   wr_en, wr_addr, wr_data  S2 write request
module histogram_accum_pipe
   import histogram_frame_controller_pkg::*;
(
   input  logic                   clk_sys,
   input  logic                   rst,
   input  logic                   accept,
   input  logic [HIST_ADDR_W-1:0] pixel,
   input  logic [HIST_CNT_W-1:0]  rd_data,
   input  logic                   port_wr_en,
   input  logic [HIST_ADDR_W-1:0] port_wr_addr,
   input  logic [HIST_CNT_W-1:0]  port_wr_data,
   output logic [HIST_ADDR_W-1:0] rd_addr,
   output logic                   wr_en,
   output logic [HIST_ADDR_W-1:0] wr_addr,
   output logic [HIST_CNT_W-1:0]  wr_data
);

   logic                   s2_valid;
   logic [HIST_ADDR_W-1:0] s2_addr;
   logic                   last_valid;
   logic [HIST_ADDR_W-1:0] last_addr;
   logic [HIST_CNT_W-1:0]  last_data;
   logic [HIST_CNT_W-1:0]  base;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         s2_addr    <= '0;
         last_valid <= 1'b0;
         last_addr  <= '0;
         last_data  <= '0;
      end else begin
         s2_valid   <= accept;
         if (accept) begin
            s2_addr <= pixel;
         end
         last_valid <= port_wr_en;
         last_addr  <= port_wr_addr;
         last_data  <= port_wr_data;
      end
   end

   always_comb begin
      base = rd_data;
      if (last_valid && (last_addr == s2_addr)) begin
         base = last_data;
      end
   end

   assign rd_addr = pixel;
   assign wr_en   = s2_valid;
   assign wr_addr = s2_addr;
   assign wr_data = sat_inc(base);

endmodule

// File: rtl/histogram_frame_controller.sv
// histogram_frame_controller
// Owns the 256-bin, 20-bit histogram dual-port RAM. Each frame clears all
// bins, accumulates one pixel per cycle, drains the pipeline, then scans the
// bins for the largest value and the 50%-cumulative threshold bin. Between
// frames the read port belongs to the histogram displayer.
// Ports:
//   iClk, iReset            clock, synchronous active-high reset
//   iStart                  pulse: start a frame (honoured in IDLE/DONE)
//   iValid, iPixel, oReady  pixel stream, accepted on iValid & oReady
//   iFrameEnd               pulse: last pixel presented (honoured in ACCUM)
//   iDispAddr               displayer bin address
//   oRdAddr, iRdData        RAM port A (1-cycle read latency)
//   oWrAddr, oWrData, oWrEn RAM port B
//   oMaxValue, oThreshPoint50, oTotal  results of the last completed frame
//   oBusy, oDone            frame in progress, completion pulse
//
// state | meaning
// IDLE  | no frame yet; displayer owns the read port
// CLEAR | write 0 to bins 0..255, one per cycle; total cleared
// ACCUM | accept pixels, read-modify-write each bin
// DRAIN | finish the last pipelined write
// SCAN  | read bins 0..255, track max and cumulative sum
// DONE  | results latched; displayer owns the read port
module histogram_frame_controller
   import histogram_frame_controller_pkg::*;
(
   input  logic                   iClk,
   input  logic                   iReset,
   input  logic                   iStart,
   input  logic                   iValid,
   input  logic [HIST_ADDR_W-1:0] iPixel,
   input  logic                   iFrameEnd,
   input  logic [HIST_ADDR_W-1:0] iDispAddr,
   output logic                   oReady,
   output logic [HIST_ADDR_W-1:0] oRdAddr,
   input  logic [HIST_CNT_W-1:0]  iRdData,
   output logic [HIST_ADDR_W-1:0] oWrAddr,
   output logic [HIST_CNT_W-1:0]  oWrData,
   output logic                   oWrEn,
   output logic [HIST_CNT_W-1:0]  oMaxValue,
   output logic [HIST_ADDR_W-1:0] oThreshPoint50,
   output logic [HIST_CNT_W-1:0]  oTotal,
   output logic                   oBusy,
   output logic                   oDone
);

   hist_state_t state_q, state_d;

   // Shared clear/scan counter; SCAN needs 257 cycles so one extra bit.
   logic [HIST_ADDR_W:0]   cnt_q;
   logic [HIST_CNT_W-1:0]  tot_q;
   logic [HIST_CNT_W-1:0]  max_run_q;
   logic [HIST_CNT_W:0]    cum_q;
   logic [HIST_ADDR_W-1:0] thresh_run_q;
   logic                   found_q;
   logic [HIST_CNT_W-1:0]  max_q;
   logic [HIST_ADDR_W-1:0] thresh_q;
   logic [HIST_CNT_W-1:0]  total_q;
   logic                   done_q;

   logic                   accept;
   logic                   scan_vld;
   logic                   scan_last;
   logic [HIST_ADDR_W-1:0] bin_idx;
   logic [HIST_CNT_W-1:0]  max_nxt;
   logic [HIST_CNT_W:0]    cum_nxt;
   logic                   hit;

   logic [HIST_ADDR_W-1:0] pipe_rd_addr;
   logic                   pipe_wr_en;
   logic [HIST_ADDR_W-1:0] pipe_wr_addr;
   logic [HIST_CNT_W-1:0]  pipe_wr_data;

   assign accept = iValid && (state_q == ST_ACCUM);

   histogram_accum_pipe u_pipe (
      .clk_sys      (iClk),
      .rst          (iReset),
      .accept       (accept),
      .pixel        (iPixel),
      .rd_data      (iRdData),
      .port_wr_en   (oWrEn),
      .port_wr_addr (oWrAddr),
      .port_wr_data (oWrData),
      .rd_addr      (pipe_rd_addr),
      .wr_en        (pipe_wr_en),
      .wr_addr      (pipe_wr_addr),
      .wr_data      (pipe_wr_data)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (iStart) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == 9'd255) begin
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (iFrameEnd) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: state_d = ST_SCAN;
         ST_SCAN: begin
            if (scan_last) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      oRdAddr = iDispAddr;
      oWrEn   = 1'b0;
      oWrAddr = '0;
      oWrData = '0;
      oReady  = 1'b0;
      oBusy   = 1'b1;
      case (state_q)
         ST_IDLE, ST_DONE: oBusy = 1'b0;
         ST_CLEAR: begin
            oWrEn   = 1'b1;
            oWrAddr = cnt_q[HIST_ADDR_W-1:0];
         end
         ST_ACCUM, ST_DRAIN: begin
            oReady  = (state_q == ST_ACCUM);
            oRdAddr = pipe_rd_addr;
            oWrEn   = pipe_wr_en;
            oWrAddr = pipe_wr_addr;
            oWrData = pipe_wr_data;
         end
         ST_SCAN: oRdAddr = cnt_q[HIST_ADDR_W-1:0];
         default: oBusy = 1'b0;
      endcase
   end

   // Scan datapath: at count k (1..256) iRdData holds bin k-1.
   assign scan_vld  = (state_q == ST_SCAN) && (cnt_q != '0);
   assign scan_last = (cnt_q == 9'd256);
   assign bin_idx   = cnt_q[HIST_ADDR_W-1:0] - 8'd1;
   assign max_nxt   = (iRdData > max_run_q) ? iRdData : max_run_q;
   assign cum_nxt   = cum_q + {1'b0, iRdData};
   // cum*2 >= total is the same test as cum >= ceil(total/2).
   assign hit       = !found_q && ({cum_nxt, 1'b0} >= {2'b00, tot_q});

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         tot_q        <= '0;
         max_run_q    <= '0;
         cum_q        <= '0;
         thresh_run_q <= '0;
         found_q      <= 1'b0;
         max_q        <= '0;
         thresh_q     <= '0;
         total_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;

         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if ((state_q == ST_CLEAR) || (state_q == ST_SCAN)) begin
            cnt_q <= cnt_q + 9'd1;
         end

         if (state_q == ST_CLEAR) begin
            tot_q <= '0;
         end else if (accept) begin
            tot_q <= sat_inc(tot_q);
         end

         if (state_q == ST_DRAIN) begin
            max_run_q    <= '0;
            cum_q        <= '0;
            thresh_run_q <= '0;
            found_q      <= 1'b0;
         end else if (scan_vld) begin
            max_run_q <= max_nxt;
            cum_q     <= cum_nxt;
            if (hit) begin
               thresh_run_q <= bin_idx;
               found_q      <= 1'b1;
            end
            // Results move together, so the displayer never sees a mix of frames.
            if (scan_last) begin
               done_q  <= 1'b1;
               total_q <= tot_q;
               if (tot_q == '0) begin
                  max_q    <= '0;
                  thresh_q <= '0;
               end else begin
                  max_q    <= max_nxt;
                  thresh_q <= hit ? bin_idx : thresh_run_q;
               end
            end
         end
      end
   end

   assign oMaxValue      = max_q;
   assign oThreshPoint50 = thresh_q;
   assign oTotal         = total_q;
   assign oDone          = done_q;

endmodule

// File: tb/tb_histogram_frame_controller.sv
module tb_histogram_frame_controller;
   import histogram_frame_controller_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, valid, frame_end, preload_req;
   logic [7:0]  pixel, disp_addr;
   logic        ready, wr_en, busy, done;
   logic [7:0]  rd_addr, wr_addr, thresh;
   logic [19:0] rd_data, wr_data, max_v, total;

   // Read-first dual-port RAM: a same-cycle write is not visible to the read.
   logic [19:0] mem [256];
   always @(posedge clk) begin
      rd_data <= mem[rd_addr];
      if (preload_req) begin
         for (int i = 0; i < 256; i++) mem[i] <= (i == 3) ? 20'hFFFFF : 20'h0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   histogram_frame_controller dut (
      .iClk(clk), .iReset(rst), .iStart(start), .iValid(valid), .iPixel(pixel),
      .iFrameEnd(frame_end), .iDispAddr(disp_addr), .oReady(ready),
      .oRdAddr(rd_addr), .iRdData(rd_data), .oWrAddr(wr_addr), .oWrData(wr_data),
      .oWrEn(wr_en), .oMaxValue(max_v), .oThreshPoint50(thresh), .oTotal(total),
      .oBusy(busy), .oDone(done)
   );

   typedef struct {
      logic [19:0] mx;
      logic [7:0]  th;
      logic [19:0] tot;
   } res_t;

   int          checks = 0;
   int          errors = 0;
   int unsigned exp_bins [256];
   int unsigned exp_total;
   res_t        sb_q [$];
   res_t        exp;
   localparam int unsigned SAT = 32'h000F_FFFF;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) exp_bins[i] = 0;
      exp_total = 0;
   endtask

   task automatic model_pixel(input int p);
      if (exp_bins[p] < SAT) exp_bins[p] = exp_bins[p] + 1;
      if (exp_total < SAT) exp_total = exp_total + 1;
   endtask

   function automatic res_t model_result();
      res_t        r;
      longint      cum;
      int unsigned mx;
      bit          found;
      cum = 0; mx = 0; found = 1'b0;
      r.th = 8'd0;
      r.tot = exp_total[19:0];
      if (exp_total != 0) begin
         for (int i = 0; i < 256; i++) begin
            if (exp_bins[i] > mx) mx = exp_bins[i];
            cum += longint'(exp_bins[i]);
            if (!found && (2 * cum >= longint'(exp_total))) begin
               r.th = 8'(i);
               found = 1'b1;
            end
         end
      end
      r.mx = mx[19:0];
      return r;
   endfunction

   task automatic do_clear(output bit ok);
      start = 1'b1;
      step();
      start = 1'b0;
      model_clear();
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic send(input int p, input int gap);
      valid = 1'b1;
      pixel = p[7:0];
      model_pixel(p);
      step();
      valid = 1'b0;
      repeat (gap) step();
   endtask

   task automatic end_frame(input bit with_px, input int p);
      frame_end = 1'b1;
      if (with_px) begin
         valid = 1'b1;
         pixel = p[7:0];
         model_pixel(p);
      end
      step();
      frame_end = 1'b0;
      valid = 1'b0;
      sb_q.push_back(model_result());
   endtask

   task automatic wait_done(output bit got);
      got = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic read_bin(input int a, output logic [19:0] d);
      disp_addr = a[7:0];
      step();
      d = rd_data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      checks += 7;
      if (wr_en !== 1'b0) begin errors++; $display("FAIL reset wr_en got %b want 0", wr_en); end
      if (ready !== 1'b0) begin errors++; $display("FAIL reset ready got %b want 0", ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done); end
      if (max_v !== 20'h0) begin errors++; $display("FAIL reset max got %h want 0", max_v); end
      if (thresh !== 8'h0) begin errors++; $display("FAIL reset thresh got %h want 0", thresh); end
      if (total !== 20'h0) begin errors++; $display("FAIL reset total got %h want 0", total); end
      disp_addr = 8'hA5;
      #1;
      checks++;
      if (rd_addr !== 8'hA5) begin errors++; $display("FAIL idle rd_addr got %h want a5", rd_addr); end
   endtask

   task automatic test_clear();
      int          idx;
      bit          got;
      logic [19:0] d;
      start = 1'b1;
      step();
      start = 1'b0;
      model_clear();
      idx = 0;
      for (int c = 0; c < 300 && ready !== 1'b1; c++) begin
         if (wr_en === 1'b1) begin
            checks++;
            if (wr_addr !== 8'(idx) || wr_data !== 20'h0) begin
               errors++;
               $display("FAIL clear write %0d got addr %h data %h want addr %h data 0", idx, wr_addr, wr_data, 8'(idx));
            end
            idx++;
         end
         step();
      end
      checks += 2;
      if (idx != 256) begin errors++; $display("FAIL clear count got %0d want 256", idx); end
      if (ready !== 1'b1) begin errors++; $display("FAIL clear ready got %b want 1", ready); end
      end_frame(1'b0, 0);
      wait_done(got);
      exp = sb_q.pop_front();
      checks += 4;
      if (!got) begin errors++; $display("FAIL empty done timeout got 0 want 1"); end
      if (max_v !== exp.mx) begin errors++; $display("FAIL empty max got %h want %h", max_v, exp.mx); end
      if (thresh !== exp.th) begin errors++; $display("FAIL empty thresh got %h want %h", thresh, exp.th); end
      if (total !== exp.tot) begin errors++; $display("FAIL empty total got %h want %h", total, exp.tot); end
      foreach (exp_bins[i]) begin
         if (i == 0 || i == 77 || i == 255) begin
            read_bin(i, d);
            checks++;
            if (d !== 20'h0) begin errors++; $display("FAIL cleared bin %0d got %h want 0", i, d); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit          ok, got;
      logic [19:0] d;
      do_clear(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b clear timeout got 0 want 1"); end
      send(5, 0); send(5, 0); send(5, 0); send(7, 0); send(5, 0);
      end_frame(1'b0, 0);
      wait_done(got);
      exp = sb_q.pop_front();
      checks += 4;
      if (!got) begin errors++; $display("FAIL b2b done timeout got 0 want 1"); end
      if (max_v !== exp.mx) begin errors++; $display("FAIL b2b max got %h want %h", max_v, exp.mx); end
      if (thresh !== exp.th) begin errors++; $display("FAIL b2b thresh got %h want %h", thresh, exp.th); end
      if (total !== exp.tot) begin errors++; $display("FAIL b2b total got %h want %h", total, exp.tot); end
      step();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL b2b done pulse got %b want 0", done); end
      read_bin(5, d);
      checks++;
      if (d !== 20'd4) begin errors++; $display("FAIL b2b bin5 got %0d want 4", d); end
      read_bin(7, d);
      checks++;
      if (d !== 20'd1) begin errors++; $display("FAIL b2b bin7 got %0d want 1", d); end
   endtask

   task automatic test_gaps();
      bit          ok, got;
      logic [19:0] d;
      do_clear(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL gaps clear timeout got 0 want 1"); end
      send(10, 0);
      send(20, 3);
      end_frame(1'b1, 10);
      wait_done(got);
      exp = sb_q.pop_front();
      checks += 4;
      if (!got) begin errors++; $display("FAIL gaps done timeout got 0 want 1"); end
      if (max_v !== exp.mx) begin errors++; $display("FAIL gaps max got %h want %h", max_v, exp.mx); end
      if (thresh !== exp.th) begin errors++; $display("FAIL gaps thresh got %h want %h", thresh, exp.th); end
      if (total !== exp.tot) begin errors++; $display("FAIL gaps total got %h want %h", total, exp.tot); end
      read_bin(10, d);
      checks++;
      if (d !== 20'd2) begin errors++; $display("FAIL gaps bin10 got %0d want 2", d); end
      read_bin(20, d);
      checks++;
      if (d !== 20'd1) begin errors++; $display("FAIL gaps bin20 got %0d want 1", d); end
   endtask

   task automatic test_saturation();
      bit          got;
      logic [19:0] d;
      rst = 1'b1;
      preload_req = 1'b1;
      step();
      rst = 1'b0;
      preload_req = 1'b0;
      model_clear();
      exp_bins[3] = SAT;
      force dut.state_q = ST_ACCUM;
      step();
      release dut.state_q;
      #1;
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL sat forced ready got %b want 1", ready); end
      send(3, 0);
      send(3, 0);
      end_frame(1'b0, 0);
      wait_done(got);
      exp = sb_q.pop_front();
      checks += 4;
      if (!got) begin errors++; $display("FAIL sat done timeout got 0 want 1"); end
      if (max_v !== exp.mx) begin errors++; $display("FAIL sat max got %h want %h", max_v, exp.mx); end
      if (thresh !== exp.th) begin errors++; $display("FAIL sat thresh got %h want %h", thresh, exp.th); end
      if (total !== exp.tot) begin errors++; $display("FAIL sat total got %h want %h", total, exp.tot); end
      read_bin(3, d);
      checks++;
      if (d !== 20'hFFFFF) begin errors++; $display("FAIL sat bin3 got %h want fffff", d); end
   endtask

   task automatic test_full_frame();
      bit          ok, got;
      int unsigned a;
      do_clear(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL frame clear timeout got 0 want 1"); end
      // Reduced 320x100 frame keeps the run short while still wrapping X past 255.
      for (int y = 0; y < 100; y++) begin
         for (int x = 0; x < 320; x++) send(x % 256, 0);
      end
      end_frame(1'b0, 0);
      wait_done(got);
      exp = sb_q.pop_front();
      checks += 4;
      if (!got) begin errors++; $display("FAIL frame done timeout got 0 want 1"); end
      if (max_v !== exp.mx) begin errors++; $display("FAIL frame max got %h want %h", max_v, exp.mx); end
      if (thresh !== exp.th) begin errors++; $display("FAIL frame thresh got %h want %h", thresh, exp.th); end
      if (total !== exp.tot) begin errors++; $display("FAIL frame total got %0d want %0d", total, exp.tot); end
      for (int i = 0; i < 16; i++) begin
         a = (i == 0) ? 0 : (i == 1) ? 255 : $urandom_range(0, 255);
         disp_addr = a[7:0];
         #1;
         checks++;
         if (rd_addr !== a[7:0]) begin errors++; $display("FAIL done rd_addr got %h want %h", rd_addr, a[7:0]); end
         step();
         checks++;
         if (rd_data !== exp_bins[a][19:0]) begin errors++; $display("FAIL frame bin %0d got %0d want %0d", a, rd_data, exp_bins[a]); end
      end
   endtask

   task automatic test_reset_mid();
      bit          ok, got;
      logic [19:0] d;
      do_clear(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mid clear timeout got 0 want 1"); end
      send(9, 0);
      send(9, 0);
      valid = 1'b1;
      pixel = 8'd9;
      rst = 1'b1;
      step();
      valid = 1'b0;
      checks += 8;
      if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL mid state got %0d want IDLE", dut.state_q); end
      if (wr_en !== 1'b0) begin errors++; $display("FAIL mid wr_en got %b want 0", wr_en); end
      if (ready !== 1'b0) begin errors++; $display("FAIL mid ready got %b want 0", ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid busy got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL mid done got %b want 0", done); end
      if (max_v !== 20'h0) begin errors++; $display("FAIL mid max got %h want 0", max_v); end
      if (thresh !== 8'h0) begin errors++; $display("FAIL mid thresh got %h want 0", thresh); end
      if (total !== 20'h0) begin errors++; $display("FAIL mid total got %h want 0", total); end
      rst = 1'b0;
      step();
      do_clear(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL post clear timeout got 0 want 1"); end
      send(200, 0); send(1, 2); send(200, 0);
      end_frame(1'b1, 1);
      wait_done(got);
      exp = sb_q.pop_front();
      checks += 4;
      if (!got) begin errors++; $display("FAIL post done timeout got 0 want 1"); end
      if (max_v !== exp.mx) begin errors++; $display("FAIL post max got %h want %h", max_v, exp.mx); end
      if (thresh !== exp.th) begin errors++; $display("FAIL post thresh got %h want %h", thresh, exp.th); end
      if (total !== exp.tot) begin errors++; $display("FAIL post total got %h want %h", total, exp.tot); end
      read_bin(9, d);
      checks++;
      if (d !== 20'd0) begin errors++; $display("FAIL post bin9 got %0d want 0", d); end
      read_bin(200, d);
      checks++;
      if (d !== 20'd2) begin errors++; $display("FAIL post bin200 got %0d want 2", d); end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      frame_end = 1'b0;
      preload_req = 1'b0;
      pixel = 8'h0;
      disp_addr = 8'h0;
      model_clear();
      test_reset();
      test_clear();
      test_back_to_back();
      test_gaps();
      test_saturation();
      test_full_frame();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
